// File: rtl/stream_register.sv
// Valid/ready pipeline register: two-entry skid buffer (BURST="yes") or half-rate single stage.
// Optional statistics outputs oCount/oStall are enabled by defining STREAM_REGISTER_STATS_EN.
module stream_register #(
  parameter int unsigned WIDTH = 8,
  parameter string       BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM
`ifdef STREAM_REGISTER_STATS_EN
  ,
  output logic [31:0]      oCount,
  output logic             oStall
`endif
);

  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic             acceptA;
  logic             takeB;

  assign acceptA   = iValid_AM & oReady_AM;
  assign takeB     = mainValid & iReady_BM;
  assign oValid_BM = mainValid;
  assign oData_BM  = mainData;

  if (BURST == "yes") begin : gSkid
    logic             skidValid;
    logic [WIDTH-1:0] skidData;

    // Ready depends only on the skid flop, so no input reaches oReady_AM combinationally.
    assign oReady_AM = ~skidValid;

    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        mainValid <= 1'b0;
        skidValid <= 1'b0;
        mainData  <= '0;
        skidData  <= '0;
      end else begin
        unique case ({mainValid, skidValid})
          2'b00: begin
            if (acceptA) begin
              mainValid <= 1'b1;
              mainData  <= iData_AM;
            end
          end
          2'b10: begin
            if (acceptA && takeB) begin
              mainData <= iData_AM;
            end else if (acceptA) begin
              skidValid <= 1'b1;
              skidData  <= iData_AM;
            end else if (takeB) begin
              mainValid <= 1'b0;
            end
          end
          2'b11: begin
            if (takeB) begin
              mainData  <= skidData;
              skidValid <= 1'b0;
            end
          end
          default: begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
          end
        endcase
      end
    end
  end else begin : gSingle
    assign oReady_AM = ~mainValid;

    // acceptA and takeB are mutually exclusive here: ready is only high while empty.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        mainValid <= 1'b0;
        mainData  <= '0;
      end else if (acceptA) begin
        mainValid <= 1'b1;
        mainData  <= iData_AM;
      end else if (takeB) begin
        mainValid <= 1'b0;
      end
    end
  end

`ifdef STREAM_REGISTER_STATS_EN
  logic [31:0] count;
  logic        stall;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      count <= 32'd0;
      stall <= 1'b0;
    end else begin
      if (takeB) begin
        count <= count + 32'd1;
      end
      stall <= mainValid & ~iReady_BM;
    end
  end

  assign oCount = count;
  assign oStall = stall;
`endif

endmodule

// File: tb/tb_stream_register.sv
// Self-checking bench for stream_register: index 0 is BURST="yes", index 1 is BURST="no".
// Reference is an unbounded FIFO model with per-mode capacity (2 or 1 words held).
module tb_stream_register;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vA[2];
  logic [7:0] dA[2];
  logic       rB[2];
  logic       rA[2];
  logic       vB[2];
  logic [7:0] dB[2];
`ifdef STREAM_REGISTER_STATS_EN
  logic [31:0] cnt[2];
  logic        stl[2];
`endif

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] mem[2][N];
  int         wr[2];
  int         rd[2];
  logic       expStall[2];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rb;
    logic       ev;
    logic [7:0] ed;
    logic       er;
  } vec_t;
  vec_t tbl[7];

  stream_register #(.WIDTH(8), .BURST("yes")) dutSkid (
    .iCLK      (clk),
    .iRST      (rst),
    .iValid_AM (vA[0]),
    .oReady_AM (rA[0]),
    .iData_AM  (dA[0]),
    .oValid_BM (vB[0]),
    .iReady_BM (rB[0]),
    .oData_BM  (dB[0])
`ifdef STREAM_REGISTER_STATS_EN
    ,
    .oCount    (cnt[0]),
    .oStall    (stl[0])
`endif
  );

  stream_register #(.WIDTH(8), .BURST("no")) dutSingle (
    .iCLK      (clk),
    .iRST      (rst),
    .iValid_AM (vA[1]),
    .oReady_AM (rA[1]),
    .iData_AM  (dA[1]),
    .oValid_BM (vB[1]),
    .iReady_BM (rB[1]),
    .oData_BM  (dB[1])
`ifdef STREAM_REGISTER_STATS_EN
    ,
    .oCount    (cnt[1]),
    .oStall    (stl[1])
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs set; checks outputs against the model, then advances one edge.
  task automatic stepCycle();
    int   held;
    int   cap;
    logic acc[2];
    logic tk[2];
    for (int m = 0; m < 2; m++) begin
      held = wr[m] - rd[m];
      cap  = (m == 0) ? 2 : 1;
      check($sformatf("ready%0d", m), 32'(rA[m]), 32'(held < cap));
      check($sformatf("valid%0d", m), 32'(vB[m]), 32'(held > 0));
      if (held > 0) check($sformatf("data%0d", m), 32'(dB[m]), 32'(mem[m][rd[m] % N]));
      acc[m]      = vA[m] && (held < cap);
      tk[m]       = (held > 0) && rB[m];
      expStall[m] = (held > 0) && !rB[m];
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (tk[m]) rd[m]++;
      if (acc[m]) begin
        mem[m][wr[m] % N] = dA[m];
        wr[m]++;
      end
`ifdef STREAM_REGISTER_STATS_EN
      check($sformatf("stall%0d", m), 32'(stl[m]), 32'(expStall[m]));
`endif
    end
  endtask

  // Asynchronous reset mid-cycle; traffic offered during reset must be ignored.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rstValid%0d", m), 32'(vB[m]), 32'd0);
      check($sformatf("rstData%0d", m), 32'(dB[m]), 32'd0);
      check($sformatf("rstReady%0d", m), 32'(rA[m]), 32'd1);
`ifdef STREAM_REGISTER_STATS_EN
      check($sformatf("rstCount%0d", m), cnt[m], 32'd0);
      check($sformatf("rstStall%0d", m), 32'(stl[m]), 32'd0);
`endif
      vA[m] = 1'b1;
      dA[m] = 8'hEE;
      rB[m] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) check($sformatf("inRstValid%0d", m), 32'(vB[m]), 32'd0);
    #2 rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      wr[m] = 0;
      rd[m] = 0;
      vA[m] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("postRstValid%0d", m), 32'(vB[m]), 32'd0);
      check($sformatf("postRstReady%0d", m), 32'(rA[m]), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] words8[8];
    int         base;
    int         idx;
    int         pulses;

    // {valid, data, readyB} -> {valid, data, ready} seen after the edge (skid mode)
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[5] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1};

    for (int m = 0; m < 2; m++) begin
      vA[m] = 1'b0;
      dA[m] = 8'h00;
      rB[m] = 1'b0;
      wr[m] = 0;
      rd[m] = 0;
    end
    #1;
    doReset();

    vA[1] = 1'b0;
    rB[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vA[0] = tbl[i].v;
      dA[0] = tbl[i].d;
      rB[0] = tbl[i].rb;
      stepCycle();
      check($sformatf("tblValid[%0d]", i), 32'(vB[0]), 32'(tbl[i].ev));
      check($sformatf("tblData[%0d]", i), 32'(dB[0]), 32'(tbl[i].ed));
      check($sformatf("tblReady[%0d]", i), 32'(rA[0]), 32'(tbl[i].er));
    end

    // Full-rate burst: each accepted byte is on the output right after its edge.
    vA[0] = 1'b1;
    rB[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dA[0] = 8'($urandom);
      stepCycle();
      check("burstValid", 32'(vB[0]), 32'd1);
      check("burstData", 32'(dB[0]), 32'(dA[0]));
      check("burstReady", 32'(rA[0]), 32'd1);
    end
    vA[0] = 1'b0;
    stepCycle();

    // Half-rate mode: 8 words over 16 edges, ready toggling.
    for (int i = 0; i < 8; i++) words8[i] = 8'(i * 37 + 5);
    base  = wr[1];
    vA[1] = 1'b1;
    rB[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      idx   = wr[1] - base;
      dA[1] = words8[idx & 7];
      stepCycle();
      check("halfReady", 32'(rA[1]), 32'(c % 2 == 0));
      check("halfValid", 32'(vB[1]), 32'(c % 2 == 1));
      if (c % 2 == 1) check("halfData", 32'(dB[1]), 32'(words8[(c - 1) / 2]));
    end
    vA[1] = 1'b0;
    stepCycle();

    // Random traffic on both modes.
    for (int i = 0; i < 1000; i++) begin
      for (int m = 0; m < 2; m++) begin
        vA[m] = ($urandom % 4) != 0;
        rB[m] = ($urandom % 3) != 0;
        dA[m] = 8'($urandom);
      end
      stepCycle();
    end
    for (int m = 0; m < 2; m++) begin
      vA[m] = 1'b0;
      rB[m] = 1'b1;
    end
    for (int i = 0; i < 3; i++) stepCycle();

    // Reset with two words held in the skid variant.
    vA[0] = 1'b1;
    rB[0] = 1'b0;
    vA[1] = 1'b1;
    rB[1] = 1'b0;
    dA[0] = 8'hA1;
    dA[1] = 8'hB1;
    stepCycle();
    dA[0] = 8'hA2;
    stepCycle();
    check("fullBeforeRst", 32'(rA[0]), 32'd0);
    doReset();
    vA[0] = 1'b1;
    rB[0] = 1'b1;
    dA[0] = 8'h5A;
    stepCycle();
    check("firstAfterRst", 32'(dB[0]), 32'h5A);
    vA[0] = 1'b0;
    stepCycle();

`ifdef STREAM_REGISTER_STATS_EN
    doReset();
    pulses = 0;
    rB[1]  = 1'b1;
    for (int c = 0; c < 400 && rd[0] < 100; c++) begin
      vA[0] = wr[0] < 100;
      dA[0] = 8'($urandom);
      rB[0] = !(c inside {10, 20, 30, 40, 50});
      stepCycle();
      if (stl[0]) pulses++;
    end
    check("statsTransfers", 32'(rd[0]), 32'd100);
    check("statsCount", cnt[0], 32'd100);
    check("statsStallPulses", 32'(pulses), 32'd5);
`else
    pulses = 0;
    base   = pulses;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stream_register.md
Name: stream_register

Overview:
- Single-clock valid/ready pipeline register that cuts timing paths between an upstream stream (A side, "_AM") and a downstream stream (B side, "_BM").
- Used by stream sources and datapath stages as the standard output register.
- BURST selects one of two modes:
  - Full-throughput skid buffer.
  - Minimal half-throughput single stage.

Parameters:
- WIDTH, 8: data bits per transfer.
- BURST, "yes": "yes" selects the two-entry skid buffer with 1 transfer/cycle. Any other string selects the single-entry mode with at most 1 transfer per 2 cycles.

Ports:
- iCLK  input  1  clock; all state changes on the rising edge.
- iRST  input  1  reset, asynchronous, active-high.
- iValid_AM  input  1  upstream data valid.
- oReady_AM  output  1  block can accept; registered, no combinational path from any input.
- iData_AM  input  WIDTH  upstream data.
- oValid_BM  output  1  output data valid; registered.
- iReady_BM  input  1  downstream ready.
- oData_BM  output  WIDTH  output data; registered.

Behaviour:
- Handshake rules:
  - Upstream transfer (acceptA) = iValid_AM & oReady_AM at a rising edge.
  - Downstream transfer (takeB) = oValid_BM & iReady_BM at a rising edge.
  - Upstream may present valid regardless of ready.
  - Once oValid_BM=1, oValid_BM and oData_BM stay stable until takeB.
- Reset (iRST high, asynchronous): oValid_BM=0, oData_BM=0, skid empty, oReady_AM=1. Internal skid data is cleared to 0.
- Reset mid-operation: all buffered data is discarded and no transfer occurs while iRST is high. The first acceptA is possible at the first edge after iRST falls.
- Latency: data accepted at edge k appears on oData_BM with oValid_BM=1 right after edge k, when the output stage is empty.
- Data ordering is strictly FIFO; no word is dropped or duplicated.
- oData_BM holds its last value after takeB empties the stage, so it is don't-care while invalid.
- BURST="yes" (skid buffer). State is {main valid, skid valid}, giving three states:
  - EMPTY (0,0): oReady_AM=1.
    - acceptA -> ONE; main <= iData_AM.
  - ONE (1,0): oReady_AM=1.
    - acceptA and takeB -> ONE; main <= iData_AM.
    - acceptA and no takeB -> FULL; skid <= iData_AM.
    - takeB only -> EMPTY.
  - FULL (1,1): oReady_AM=0.
    - takeB -> ONE; main <= skid.
  - oReady_AM is the registered negation of skid valid.
  - Sustains 1 transfer/cycle when iReady_BM=1.
  - After iReady_BM drops, at most one more word is absorbed into the skid; ready deasserts the following cycle.
- BURST other than "yes" (single stage):
  - oReady_AM = ~oValid_BM (registered).
  - acceptA loads main and sets valid; takeB clears valid.
  - Maximum rate is 1 word per 2 cycles.
- Simultaneous acceptA and takeB in ONE: output advances to the new word in the same edge, with no bubble.

Optional Feature:
- Macro STREAM_REGISTER_STATS_EN. When defined, adds output oCount [31:0].
  - Counts takeB events.
  - Reset to 0 by iRST.
  - Wraps modulo 2^32.
  - Also adds output oStall [0:0], which is high for one cycle after each edge where oValid_BM=1 and iReady_BM=0.
- When not defined, neither port nor any counter logic exists.

Test Plan:
- BURST="yes", WIDTH=8, iReady_BM=1, stream 256 random bytes with iValid_AM=1 continuously -> 256 outputs in order, one per cycle, first output valid 1 cycle after first accept, oReady_AM stays 1.
- BURST="yes", hold iReady_BM=0 while feeding 0x11,0x22,0x33 -> oData_BM=0x11 valid, 0x22 held in skid, oReady_AM=0 from the next cycle, 0x33 not accepted. Then release iReady_BM -> outputs 0x11,0x22,0x33 in order.
- BURST="no", continuous valid and ready, 8 words -> one output every 2 cycles, oReady_AM toggles 1/0, data in order.
- Random iValid_AM/iReady_BM for 1000 cycles in both modes -> output sequence equals input sequence and oData_BM is stable while stalled.
- Assert iRST asynchronously mid-stream with 2 words buffered -> oValid_BM=0 and oData_BM=0 immediately, oReady_AM=1, no stale word emitted after release.
- With STREAM_REGISTER_STATS_EN, 100 transfers with 5 stalled cycles -> oCount=100, oStall pulsed 5 times.
